alu_dispatch: RTL and testbench
===============================

# alu_dispatch

Sequential front end for the combinational RV32I integer ALU: accepts R-type (OP) and I-type (OP-IMM) instruction words over a valid/ready handshake and decodes them. It reads a local 32×32 register file and drives operands plus funct3/funct7 to the ALU. It then writes the ALU result back to the destination register. The block is the producer and consumer on the ALU's interface: one decode stage and one execute/writeback stage, with result forwarding and an illegal-instruction halt.

## Interface

Parameters:
- RETIRE_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction word present
- instr_ready  out  1  block can accept; transfer when valid && ready
- instr  in  32  RV32I instruction word
- alu_a  out  32  ALU operand A (rs1 value)
- alu_b  out  32  ALU operand B (rs2 value or sign-extended imm[11:0])
- alu_funct3  out  3  ALU funct3
- alu_funct7  out  7  ALU funct7
- alu_result  in  32  combinational ALU result for the current alu_* drive
- ex_valid  out  1  execute stage holds a legal op this cycle
- illegal  out  1  sticky illegal-instruction flag
- illegal_clear  in  1  pulse to leave HALT
- retired  out  RETIRE_W  count of executed legal instructions, wraps
- dbg_addr  in  5  debug register-file read address
- dbg_data  out  32  combinational read of rf[dbg_addr]; x0 reads 0

## Operation

- **FSM states:** RUN, HALT. Reset → RUN. instr_ready = (state == RUN).
- **Decode, on an accepted transfer:** opcode = instr[6:0], rd = [11:7], funct3 = [14:12], rs1 = [19:15], rs2 = [24:20], imm = sign-extend [31:20].
- **Legal OP (0110011):**
  - funct7 = 0x00 for any funct3.
  - funct7 = 0x20 only when funct3 ∈ {000, 101}.
  - B = rs2 value; alu_funct7 = instr[31:25].
- **Legal OP-IMM (0010011):**
  - funct3 = 001 requires imm[11:5] = 0x00.
  - funct3 = 101 requires imm[11:5] ∈ {0x00, 0x20}.
  - All other funct3 values are legal.
  - B = sign-extended imm.
  - alu_funct7 = imm[11:5] when funct3 = 101; otherwise 0x00. This forces ADDI to add regardless of imm bits.
- **Illegal instruction (any other encoding):**
  - The transfer still completes.
  - The instruction is not executed: no writeback, no retire.
  - illegal ← 1 and state ← HALT.
- **HALT:**
  - illegal_clear = 1 → RUN and illegal ← 0 on the next edge.
  - illegal_clear in RUN is ignored.
- **Operand read with forwarding:** if ex_valid && ex_rd == rsN && rsN != 0, the operand takes alu_result; otherwise it takes rf[rsN]. x0 always reads 0.
- **Execute/writeback:**
  - While ex_valid, at the end of the cycle: rf[ex_rd] ← alu_result if ex_rd != 0, and retired += 1 (including rd = x0).
  - When the execute stage is empty (bubble): ex_valid = 0 and alu_a/alu_b/alu_funct3/alu_funct7 = 0.
- **Register file:** 31 writable registers; x0 is hardwired to 0.

## Timing

- **Reset:** all outputs and state are cleared asynchronously.
  - instr_ready = 1 (RUN), ex_valid = 0, alu_* = 0, illegal = 0, retired = 0, all registers = 0.
- **Latency:** an instruction accepted at edge N drives alu_* and ex_valid = 1 during cycle N+1. Its result is written at edge N+2 and is visible on dbg_data from N+2.
- **Throughput:** one instruction per cycle; back-to-back dependents forward with no stall.
- **Illegal timing:** an illegal accept at edge N gives illegal = 1 and instr_ready = 0 from N+1, with ex_valid = 0 in N+1. A legal instruction already in execute completes normally.
- **Simultaneous write and debug read:** if dbg_addr equals the register being written this cycle, dbg_data shows the old value until the edge.
- **Reset mid-operation:** the in-flight instruction is discarded with no writeback.
- **Counter wrap:** retired wraps from all-ones to 0.

## Test plan

- **Reset:** assert rst_n = 0 mid-stream, including between clock edges → all outputs at reset values immediately; dbg reads of x1..x31 return 0.
- **ADDI with 0x20 imm bits:** 0x40000093 (addi x1,x0,1024) → cycle N+1: alu_b = 0x400, alu_funct7 = 0x00; x1 = 0x00000400; retired = 1.
- **Back-to-back forwarding chain:** 0xFFF00093, 0x01F09093, 0x4040D113, 0x401101B3 on consecutive cycles → the slli stage shows alu_a = 0xFFFFFFFF (forwarded). Final registers: x1 = 0x80000000, x2 = 0xF8000000, x3 = 0x78000000. retired = 4.
- **x0 destination:** 0x00500013 (addi x0,x0,5) → x0 reads 0; retired increments.
- **Illegal encoding:** instr 0x00000000 with valid → accepted; illegal = 1 and instr_ready = 0 next cycle; no register change. Then pulse illegal_clear → illegal = 0 and instr_ready = 1 the following cycle.
- **Illegal SLLI encoding:** 0x40109093 (slli with imm[11:5] = 0x20) → illegal = 1; x1 unchanged.

Source files
------------

// File: rtl/alu_dispatch.sv
// Two-stage RV32I OP/OP-IMM front end: decode + operand read, then execute/writeback
// through an external combinational ALU. Illegal encodings park the block in HALT.
module alu_dispatch #(
  parameter int RETIRE_W = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_instr_valid,
  output logic                o_instr_ready,
  input  logic [31:0]         i_instr,
  output logic [31:0]         o_alu_a,
  output logic [31:0]         o_alu_b,
  output logic [2:0]          o_alu_funct3,
  output logic [6:0]          o_alu_funct7,
  input  logic [31:0]         i_alu_result,
  output logic                o_ex_valid,
  output logic                o_illegal,
  input  logic                i_illegal_clear,
  output logic [RETIRE_W-1:0] o_retired,
  input  logic [4:0]          i_dbg_addr,
  output logic [31:0]         o_dbg_data
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  state_t r_state;
  state_t w_stateNext;

  logic [31:0]         r_rf [0:31];
  logic                r_exValid;
  logic [4:0]          r_exRd;
  logic [31:0]         r_aluA;
  logic [31:0]         r_aluB;
  logic [2:0]          r_aluF3;
  logic [6:0]          r_aluF7;
  logic [RETIRE_W-1:0] r_retired;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [6:0]  w_top7;
  logic [31:0] w_imm;
  logic        w_isOp;
  logic        w_isOpImm;
  logic        w_opLegal;
  logic        w_immLegal;
  logic        w_legal;
  logic        w_accept;
  logic [31:0] w_rs1Val;
  logic [31:0] w_rs2Val;
  logic [31:0] w_bNext;
  logic [6:0]  w_f7Next;

  assign w_opcode  = i_instr[6:0];
  assign w_rd      = i_instr[11:7];
  assign w_funct3  = i_instr[14:12];
  assign w_rs1     = i_instr[19:15];
  assign w_rs2     = i_instr[24:20];
  assign w_top7    = i_instr[31:25];
  assign w_imm     = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_isOp    = (w_opcode == OPC_OP);
  assign w_isOpImm = (w_opcode == OPC_OP_IMM);

  assign w_opLegal = w_isOp && ((w_top7 == 7'h00) ||
                     ((w_top7 == 7'h20) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));

  always_comb begin
    w_immLegal = w_isOpImm;
    if (w_funct3 == 3'b001)
      w_immLegal = w_isOpImm && (w_top7 == 7'h00);
    else if (w_funct3 == 3'b101)
      w_immLegal = w_isOpImm && ((w_top7 == 7'h00) || (w_top7 == 7'h20));
  end

  assign w_legal  = w_opLegal || w_immLegal;
  assign w_accept = i_instr_valid && (r_state == RUN);

  // The instruction in execute has not reached the file yet, so its result bypasses it.
  always_comb begin
    w_rs1Val = r_rf[w_rs1];
    if (w_rs1 == 5'd0)
      w_rs1Val = 32'd0;
    else if (r_exValid && (r_exRd == w_rs1))
      w_rs1Val = i_alu_result;
    w_rs2Val = r_rf[w_rs2];
    if (w_rs2 == 5'd0)
      w_rs2Val = 32'd0;
    else if (r_exValid && (r_exRd == w_rs2))
      w_rs2Val = i_alu_result;
  end

  // Only shifts-right look at funct7 for OP-IMM; everything else must add/compare plainly.
  assign w_bNext  = w_isOp ? w_rs2Val : w_imm;
  assign w_f7Next = (w_isOp || (w_funct3 == 3'b101)) ? w_top7 : 7'h00;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_state <= RUN;
    else
      r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      RUN:  if (w_accept && !w_legal) w_stateNext = HALT;
      HALT: if (i_illegal_clear) w_stateNext = RUN;
      default: w_stateNext = RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_exValid <= 1'b0;
      r_exRd    <= 5'd0;
      r_aluA    <= 32'd0;
      r_aluB    <= 32'd0;
      r_aluF3   <= 3'd0;
      r_aluF7   <= 7'd0;
    end else if (w_accept && w_legal) begin
      r_exValid <= 1'b1;
      r_exRd    <= w_rd;
      r_aluA    <= w_rs1Val;
      r_aluB    <= w_bNext;
      r_aluF3   <= w_funct3;
      r_aluF7   <= w_f7Next;
    end else begin
      r_exValid <= 1'b0;
      r_exRd    <= 5'd0;
      r_aluA    <= 32'd0;
      r_aluB    <= 32'd0;
      r_aluF3   <= 3'd0;
      r_aluF7   <= 7'd0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 32; i++)
        r_rf[i] <= 32'd0;
      r_retired <= '0;
    end else if (r_exValid) begin
      if (r_exRd != 5'd0)
        r_rf[r_exRd] <= i_alu_result;
      r_retired <= r_retired + 1'b1;
    end
  end

  assign o_instr_ready = (r_state == RUN);
  assign o_illegal     = (r_state == HALT);
  assign o_ex_valid    = r_exValid;
  assign o_alu_a       = r_aluA;
  assign o_alu_b       = r_aluB;
  assign o_alu_funct3  = r_aluF3;
  assign o_alu_funct7  = r_aluF7;
  assign o_retired     = r_retired;
  assign o_dbg_data    = (i_dbg_addr == 5'd0) ? 32'd0 : r_rf[i_dbg_addr];

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: an architectural (in-order, no pipeline) model predicts
// the execute-stage drive every cycle; directed vectors add literal spot checks.
module tb_alu_dispatch;

  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instrValid = 1'b0;
  logic          instrReady;
  logic [31:0]   instr = 32'd0;
  logic [31:0]   aluA;
  logic [31:0]   aluB;
  logic [2:0]    aluF3;
  logic [6:0]    aluF7;
  logic [31:0]   aluResult;
  logic          exValid;
  logic          illegal;
  logic          illegalClear = 1'b0;
  logic [RW-1:0] retired;
  logic [4:0]    dbgAddr = 5'd0;
  logic [31:0]   dbgData;

  int errors = 0;
  int checks = 0;

  alu_dispatch #(.RETIRE_W(RW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_instr_valid(instrValid), .o_instr_ready(instrReady), .i_instr(instr),
    .o_alu_a(aluA), .o_alu_b(aluB), .o_alu_funct3(aluF3), .o_alu_funct7(aluF7),
    .i_alu_result(aluResult), .o_ex_valid(exValid),
    .o_illegal(illegal), .i_illegal_clear(illegalClear),
    .o_retired(retired), .i_dbg_addr(dbgAddr), .o_dbg_data(dbgData)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] aluFn(logic [31:0] a, logic [31:0] b, logic [2:0] f3, logic [6:0] f7);
    case (f3)
      3'b000:  return f7[5] ? a - b : a + b;
      3'b001:  return a << b[4:0];
      3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011:  return (a < b) ? 32'd1 : 32'd0;
      3'b100:  return a ^ b;
      3'b101:  return f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  assign aluResult = aluFn(aluA, aluB, aluF3, aluF7);

  function automatic bit isLegal(logic [31:0] w);
    if (w[6:0] == 7'b0110011) begin
      if (w[31:25] == 7'h00) return 1'b1;
      return (w[31:25] == 7'h20) && (w[14:12] == 3'b000 || w[14:12] == 3'b101);
    end
    if (w[6:0] == 7'b0010011) begin
      if (w[14:12] == 3'b001) return w[31:25] == 7'h00;
      if (w[14:12] == 3'b101) return w[31:25] == 7'h00 || w[31:25] == 7'h20;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Architectural model: results land in mrf immediately, in program order.
  logic [31:0] mrf [0:31];
  bit          expValid = 0;
  bit          expHalt = 0;
  logic [31:0] expA = 0, expB = 0;
  logic [2:0]  expF3 = 0;
  logic [6:0]  expF7 = 0;
  int          expRetired = 0;
  logic [31:0] mw, mres;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expValid = 0; expHalt = 0; expRetired = 0;
      expA = 0; expB = 0; expF3 = 0; expF7 = 0;
      for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
    end else begin
      if (expValid) expRetired = expRetired + 1;
      expValid = 0; expA = 0; expB = 0; expF3 = 0; expF7 = 0;
      if (expHalt) begin
        if (illegalClear) expHalt = 0;
      end else if (instrValid) begin
        mw = instr;
        if (isLegal(mw)) begin
          expValid = 1;
          expA  = mrf[mw[19:15]];
          expF3 = mw[14:12];
          if (mw[6:0] == 7'b0110011) begin
            expB  = mrf[mw[24:20]];
            expF7 = mw[31:25];
          end else begin
            expB  = {{20{mw[31]}}, mw[31:20]};
            expF7 = (mw[14:12] == 3'b101) ? mw[31:25] : 7'h00;
          end
          mres = aluFn(expA, expB, expF3, expF7);
          if (mw[11:7] != 5'd0) mrf[mw[11:7]] = mres;
        end else begin
          expHalt = 1;
        end
      end
    end
  end

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("instr_ready", 32'(instrReady), 32'(!expHalt));
      checkOutput("illegal", 32'(illegal), 32'(expHalt));
      checkOutput("ex_valid", 32'(exValid), 32'(expValid));
      checkOutput("alu_a", aluA, expA);
      checkOutput("alu_b", aluB, expB);
      checkOutput("alu_funct3", 32'(aluF3), 32'(expF3));
      checkOutput("alu_funct7", 32'(aluF7), 32'(expF7));
      checkOutput("retired", 32'(retired), 32'(expRetired % (1 << RW)));
    end
  end

  task automatic applyStimulus(logic [31:0] w);
    @(negedge clk);
    instrValid = 1'b1;
    instr = w;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      instrValid = 1'b0;
      instr = 32'd0;
    end
  endtask

  task automatic checkReg(logic [4:0] r, logic [31:0] exp);
    dbgAddr = r;
    #1;
    checkOutput($sformatf("x%0d", r), dbgData, exp);
  endtask

  task automatic pulseClear();
    @(negedge clk);
    illegalClear = 1'b1;
    @(negedge clk);
    illegalClear = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    #2;
    checkOutput("reset instr_ready", 32'(instrReady), 32'd1);
    checkOutput("reset ex_valid", 32'(exValid), 32'd0);
    checkOutput("reset illegal", 32'(illegal), 32'd0);
    checkOutput("reset retired", 32'(retired), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // addi x1,x0,1024: imm bits 11:5 = 0x20 must not turn ADD into SUB
    applyStimulus(32'h40000093);
    idle(1);
    checkOutput("addi alu_b", aluB, 32'h00000400);
    checkOutput("addi alu_funct7", 32'(aluF7), 32'h0);
    checkOutput("addi ex_valid", 32'(exValid), 32'd1);
    idle(1);
    checkReg(5'd1, 32'h00000400);
    checkOutput("addi retired", 32'(retired), 32'd1);

    // back-to-back dependent chain
    applyStimulus(32'hFFF00093);
    applyStimulus(32'h01F09093);
    applyStimulus(32'h4040D113);
    checkOutput("slli fwd alu_a", aluA, 32'hFFFFFFFF);
    applyStimulus(32'h401101B3);
    idle(3);
    checkReg(5'd1, 32'h80000000);
    checkReg(5'd2, 32'hF8000000);
    checkReg(5'd3, 32'h78000000);
    checkOutput("chain retired", 32'(retired), 32'd5);

    // x0 destination
    applyStimulus(32'h00500013);
    idle(2);
    checkReg(5'd0, 32'h0);
    checkOutput("x0 retired", 32'(retired), 32'd6);

    // all-zero word is illegal; a valid word offered during HALT is ignored
    applyStimulus(32'h00000000);
    @(negedge clk);
    checkOutput("illegal set", 32'(illegal), 32'd1);
    checkOutput("halt ready", 32'(instrReady), 32'd0);
    checkOutput("halt ex_valid", 32'(exValid), 32'd0);
    instrValid = 1'b1;
    instr = 32'h00100093;
    idle(2);
    checkReg(5'd1, 32'h80000000);
    pulseClear();
    checkOutput("cleared illegal", 32'(illegal), 32'd0);
    checkOutput("cleared ready", 32'(instrReady), 32'd1);
    pulseClear();
    checkOutput("clear in RUN", 32'(illegal), 32'd0);

    // slli with imm[11:5] = 0x20
    applyStimulus(32'h40109093);
    idle(2);
    checkOutput("bad slli illegal", 32'(illegal), 32'd1);
    checkReg(5'd1, 32'h80000000);
    pulseClear();

    // debug read during the write cycle shows the old value
    applyStimulus(32'h00700293);
    idle(1);
    checkReg(5'd5, 32'h0);
    idle(1);
    checkReg(5'd5, 32'h7);

    // legal op in execute completes while the following illegal one halts
    applyStimulus(32'h00900313);
    applyStimulus(32'h00000000);
    idle(2);
    checkReg(5'd6, 32'h9);
    checkOutput("illegal after legal", 32'(illegal), 32'd1);
    pulseClear();

    // ten increments push the retire count past its wrap point
    for (int i = 0; i < 10; i++) applyStimulus(32'h00140413);
    idle(2);
    checkReg(5'd8, 32'd10);
    checkOutput("retired wrap", 32'(retired), 32'd2);

    for (int r = 0; r < 32; r++) checkReg(5'(r), mrf[r]);

    // asynchronous reset between edges with an instruction in execute
    applyStimulus(32'h00300393);
    @(posedge clk);
    #2;
    instrValid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset ex_valid", 32'(exValid), 32'd0);
    checkOutput("midreset alu_a", aluA, 32'd0);
    checkOutput("midreset alu_b", aluB, 32'd0);
    checkOutput("midreset retired", 32'(retired), 32'd0);
    checkOutput("midreset ready", 32'(instrReady), 32'd1);
    checkOutput("midreset illegal", 32'(illegal), 32'd0);
    for (int r = 1; r < 32; r++) checkReg(5'(r), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    checkReg(5'd7, 32'd0);
    checkOutput("post reset retired", 32'(retired), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
